// File: rtl/calc_input_sequencer.sv
// Operand-entry sequencer for the switch calculator: steps WAIT_A -> WAIT_B -> WAIT_OP -> SHOW_RESULT
// on TRIGGER, steps back on UNDO. Optional opcode range check enabled by defining CALC_OP_CHECK_EN.
module calc_input_sequencer #(
    parameter int IN_WIDTH = 16,
    parameter int OP_WIDTH = 3,
    parameter int MAX_OP   = 4
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [IN_WIDTH-1:0] IN,
    input  logic                TRIGGER,
    input  logic                UNDO,
    output logic [IN_WIDTH-1:0] A_OUT,
    output logic [IN_WIDTH-1:0] B_OUT,
    output logic [OP_WIDTH-1:0] OP_OUT,
    output logic [1:0]          STATE,
    output logic                LOAD_PULSE,
    output logic                RESULT_VALID,
    output logic                OP_ERR
);

    typedef enum logic [1:0] {
        WAIT_A      = 2'd0,
        WAIT_B      = 2'd1,
        WAIT_OP     = 2'd2,
        SHOW_RESULT = 2'd3
    } state_t;

    state_t              state_r;
    logic [IN_WIDTH-1:0] a_r;
    logic [IN_WIDTH-1:0] b_r;
    logic [OP_WIDTH-1:0] op_r;
    logic                load_r;
    logic                valid_r;
    logic                err_r;
    logic                op_legal_s;

`ifdef CALC_OP_CHECK_EN
    localparam logic [OP_WIDTH-1:0] MAX_OP_C = OP_WIDTH'(MAX_OP);

    // Opcode candidate on the switches is legal when it does not exceed MAX_OP
    always_comb begin
        if (IN[OP_WIDTH-1:0] > MAX_OP_C) begin
            op_legal_s = 1'b0;
        end else begin
            op_legal_s = 1'b1;
        end
    end
`else
    logic unused_max_op_s;
    assign unused_max_op_s = (MAX_OP != 0);
    assign op_legal_s      = 1'b1;
`endif

    // Entry FSM with operand capture; UNDO outranks TRIGGER, RESET outranks both
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= WAIT_A;
            a_r     <= '0;
            b_r     <= '0;
            op_r    <= '0;
            load_r  <= 1'b0;
            valid_r <= 1'b0;
            err_r   <= 1'b0;
        end else if (UNDO) begin
            case (state_r)
                WAIT_A: begin
                    load_r <= 1'b0;
                end
                WAIT_B: begin
                    a_r     <= '0;
                    state_r <= WAIT_A;
                    valid_r <= 1'b0;
                    load_r  <= 1'b1;
                    err_r   <= 1'b0;
                end
                WAIT_OP: begin
                    b_r     <= '0;
                    state_r <= WAIT_B;
                    valid_r <= 1'b0;
                    load_r  <= 1'b1;
                    err_r   <= 1'b0;
                end
                SHOW_RESULT: begin
                    op_r    <= '0;
                    state_r <= WAIT_OP;
                    valid_r <= 1'b0;
                    load_r  <= 1'b1;
                    err_r   <= 1'b0;
                end
                default: begin
                    state_r <= WAIT_A;
                    valid_r <= 1'b0;
                    load_r  <= 1'b0;
                end
            endcase
        end else if (TRIGGER) begin
            case (state_r)
                WAIT_A: begin
                    a_r     <= IN;
                    state_r <= WAIT_B;
                    valid_r <= 1'b0;
                    load_r  <= 1'b1;
                    err_r   <= 1'b0;
                end
                WAIT_B: begin
                    b_r     <= IN;
                    state_r <= WAIT_OP;
                    valid_r <= 1'b0;
                    load_r  <= 1'b1;
                    err_r   <= 1'b0;
                end
                WAIT_OP: begin
                    if (op_legal_s) begin
                        op_r    <= IN[OP_WIDTH-1:0];
                        state_r <= SHOW_RESULT;
                        valid_r <= 1'b1;
                        load_r  <= 1'b1;
                        err_r   <= 1'b0;
                    end else begin
                        load_r <= 1'b0;
                        err_r  <= 1'b1;
                    end
                end
                SHOW_RESULT: begin
                    a_r     <= '0;
                    b_r     <= '0;
                    op_r    <= '0;
                    state_r <= WAIT_A;
                    valid_r <= 1'b0;
                    load_r  <= 1'b1;
                    err_r   <= 1'b0;
                end
                default: begin
                    state_r <= WAIT_A;
                    valid_r <= 1'b0;
                    load_r  <= 1'b0;
                end
            endcase
        end else begin
            load_r <= 1'b0;
        end
    end

    assign A_OUT        = a_r;
    assign B_OUT        = b_r;
    assign OP_OUT       = op_r;
    assign STATE        = state_r;
    assign LOAD_PULSE   = load_r;
    assign RESULT_VALID = valid_r;
    assign OP_ERR       = err_r;

endmodule

// File: tb/tb_calc_input_sequencer.sv
// Directed-vector bench for calc_input_sequencer; follows CALC_OP_CHECK_EN when it is defined.
module tb_calc_input_sequencer;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [15:0] IN = 16'h0000;
    logic        TRIGGER = 1'b0;
    logic        UNDO = 1'b0;
    logic [15:0] A_OUT;
    logic [15:0] B_OUT;
    logic [2:0]  OP_OUT;
    logic [1:0]  STATE;
    logic        LOAD_PULSE;
    logic        RESULT_VALID;
    logic        OP_ERR;

    int vectors = 0;
    int miscompares = 0;

    calc_input_sequencer #(.IN_WIDTH(16), .OP_WIDTH(3), .MAX_OP(4)) dut (
        .CLK(CLK), .RESET(RESET), .IN(IN), .TRIGGER(TRIGGER), .UNDO(UNDO),
        .A_OUT(A_OUT), .B_OUT(B_OUT), .OP_OUT(OP_OUT), .STATE(STATE),
        .LOAD_PULSE(LOAD_PULSE), .RESULT_VALID(RESULT_VALID), .OP_ERR(OP_ERR)
    );

    always #5 CLK = ~CLK;

    // Drive one cycle of inputs, let the edge sample them, then look 1 ns after it
    task automatic cyc(input logic t, input logic u, input logic [15:0] v);
        TRIGGER = t;
        UNDO    = u;
        IN      = v;
        @(posedge CLK);
        #1;
        TRIGGER = 1'b0;
        UNDO    = 1'b0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        cyc(1'b0, 1'b0, 16'h0000);
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({A_OUT, B_OUT, OP_OUT, STATE, LOAD_PULSE, RESULT_VALID, OP_ERR} !== 40'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got A=%h B=%h OP=%h ST=%0d LP=%b RV=%b ERR=%b, want all 0",
                     A_OUT, B_OUT, OP_OUT, STATE, LOAD_PULSE, RESULT_VALID, OP_ERR);
        end
    endtask

    task automatic test_capture_sequence();
        logic [15:0] vals [3];
        int pulses;
        vals[0] = 16'h1234; vals[1] = 16'h00FF; vals[2] = 16'h0002;
        pulses = 0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, vals[i]);
            if (LOAD_PULSE === 1'b1) pulses++;
            vectors++;
            if (STATE !== 2'(i + 1)) begin
                miscompares++;
                $display("FAIL seq_state_%0d: got %0d want %0d", i, STATE, i + 1);
            end
            cyc(1'b0, 1'b0, 16'hFFFF);
            if (LOAD_PULSE === 1'b1) pulses++;
        end
        vectors++;
        if (pulses !== 3) begin
            miscompares++;
            $display("FAIL seq_load_count: got %0d want 3", pulses);
        end
        vectors++;
        if ({A_OUT, B_OUT, OP_OUT, STATE, RESULT_VALID, OP_ERR} !== {16'h1234, 16'h00FF, 3'd2, 2'd3, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL seq_result: got A=%h B=%h OP=%h ST=%0d RV=%b ERR=%b, want 1234 00ff 2 3 1 0",
                     A_OUT, B_OUT, OP_OUT, STATE, RESULT_VALID, OP_ERR);
        end
    endtask

    task automatic test_undo();
        cyc(1'b0, 1'b1, 16'h0000);
        vectors++;
        if ({STATE, OP_OUT, LOAD_PULSE, RESULT_VALID} !== {2'd2, 3'd0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL undo_from_result: got ST=%0d OP=%h LP=%b RV=%b, want 2 0 1 0",
                     STATE, OP_OUT, LOAD_PULSE, RESULT_VALID);
        end
        cyc(1'b0, 1'b1, 16'h0000);
        vectors++;
        if ({STATE, OP_OUT, B_OUT, A_OUT} !== {2'd1, 3'd0, 16'h0000, 16'h1234}) begin
            miscompares++;
            $display("FAIL undo_twice: got ST=%0d OP=%h B=%h A=%h, want 1 0 0000 1234",
                     STATE, OP_OUT, B_OUT, A_OUT);
        end
        cyc(1'b0, 1'b1, 16'h0000);
        vectors++;
        if ({STATE, A_OUT, LOAD_PULSE} !== {2'd0, 16'h0000, 1'b1}) begin
            miscompares++;
            $display("FAIL undo_to_wait_a: got ST=%0d A=%h LP=%b, want 0 0000 1", STATE, A_OUT, LOAD_PULSE);
        end
        cyc(1'b0, 1'b1, 16'h0000);
        vectors++;
        if ({STATE, A_OUT, B_OUT, OP_OUT, LOAD_PULSE} !== {2'd0, 16'h0, 16'h0, 3'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL undo_in_wait_a: got ST=%0d A=%h B=%h OP=%h LP=%b, want 0 0 0 0 0",
                     STATE, A_OUT, B_OUT, OP_OUT, LOAD_PULSE);
        end
    endtask

    task automatic test_undo_wins();
        do_reset();
        cyc(1'b1, 1'b0, 16'hAAAA);
        cyc(1'b1, 1'b0, 16'h5555);
        cyc(1'b1, 1'b1, 16'h0003);
        vectors++;
        if ({STATE, A_OUT, B_OUT, OP_OUT, LOAD_PULSE} !== {2'd1, 16'hAAAA, 16'h0000, 3'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL undo_wins: got ST=%0d A=%h B=%h OP=%h LP=%b, want 1 aaaa 0000 0 1",
                     STATE, A_OUT, B_OUT, OP_OUT, LOAD_PULSE);
        end
    endtask

    task automatic test_op_check();
        do_reset();
        cyc(1'b1, 1'b0, 16'h0011);
        cyc(1'b1, 1'b0, 16'h0022);
        cyc(1'b1, 1'b0, 16'h0007);
`ifdef CALC_OP_CHECK_EN
        vectors++;
        if ({STATE, OP_OUT, LOAD_PULSE, OP_ERR} !== {2'd2, 3'd0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL op_reject: got ST=%0d OP=%h LP=%b ERR=%b, want 2 0 0 1", STATE, OP_OUT, LOAD_PULSE, OP_ERR);
        end
        cyc(1'b0, 1'b0, 16'h0000);
        vectors++;
        if (OP_ERR !== 1'b1) begin
            miscompares++;
            $display("FAIL op_err_sticky: got %b want 1", OP_ERR);
        end
        cyc(1'b1, 1'b0, 16'h0004);
        vectors++;
        if ({STATE, OP_OUT, LOAD_PULSE, OP_ERR, RESULT_VALID} !== {2'd3, 3'd4, 1'b1, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL op_accept_max: got ST=%0d OP=%h LP=%b ERR=%b RV=%b, want 3 4 1 0 1",
                     STATE, OP_OUT, LOAD_PULSE, OP_ERR, RESULT_VALID);
        end
`else
        vectors++;
        if ({STATE, OP_OUT, LOAD_PULSE, OP_ERR, RESULT_VALID} !== {2'd3, 3'd7, 1'b1, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL op_no_check: got ST=%0d OP=%h LP=%b ERR=%b RV=%b, want 3 7 1 0 1",
                     STATE, OP_OUT, LOAD_PULSE, OP_ERR, RESULT_VALID);
        end
`endif
        cyc(1'b1, 1'b0, 16'hFFFF);
        vectors++;
        if ({STATE, A_OUT, B_OUT, OP_OUT, LOAD_PULSE, RESULT_VALID} !== {2'd0, 16'h0, 16'h0, 3'd0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL result_clear: got ST=%0d A=%h B=%h OP=%h LP=%b RV=%b, want 0 0 0 0 1 0",
                     STATE, A_OUT, B_OUT, OP_OUT, LOAD_PULSE, RESULT_VALID);
        end
    endtask

    task automatic test_reset_priority();
        do_reset();
        cyc(1'b1, 1'b0, 16'h4321);
        RESET = 1'b1;
        cyc(1'b1, 1'b0, 16'hABCD);
        RESET = 1'b0;
        vectors++;
        if ({A_OUT, B_OUT, OP_OUT, STATE, LOAD_PULSE, RESULT_VALID, OP_ERR} !== 40'h0) begin
            miscompares++;
            $display("FAIL reset_priority: got A=%h B=%h OP=%h ST=%0d LP=%b, want all 0",
                     A_OUT, B_OUT, OP_OUT, STATE, LOAD_PULSE);
        end
    endtask

    task automatic test_in_ignored();
        logic bad;
        bad = 1'b0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b0, (i % 2 == 0) ? 16'hFFFF : 16'h0F0F);
            if (A_OUT !== 16'h0000 || STATE !== 2'd0 || LOAD_PULSE !== 1'b0) bad = 1'b1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL in_ignored: got A=%h ST=%0d, want A=0000 ST=0 with no load", A_OUT, STATE);
        end
        cyc(1'b1, 1'b0, 16'h5A5A);
        cyc(1'b0, 1'b0, 16'h1111);
        vectors++;
        if ({A_OUT, STATE} !== {16'h5A5A, 2'd1}) begin
            miscompares++;
            $display("FAIL capture_edge_only: got A=%h ST=%0d, want 5a5a 1", A_OUT, STATE);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] vals [3];
        logic bad;
        vals[0] = 16'hBEEF; vals[1] = 16'hCAFE; vals[2] = 16'h0001;
        bad = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, vals[i]);
            if (STATE !== 2'(i + 1) || LOAD_PULSE !== 1'b1) bad = 1'b1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL b2b_steps: final ST=%0d LP=%b, want one step with load per cycle", STATE, LOAD_PULSE);
        end
        cyc(1'b0, 1'b0, 16'h0000);
        vectors++;
        if ({A_OUT, B_OUT, OP_OUT, STATE, LOAD_PULSE, RESULT_VALID} !== {16'hBEEF, 16'hCAFE, 3'd1, 2'd3, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL b2b_result: got A=%h B=%h OP=%h ST=%0d LP=%b RV=%b, want beef cafe 1 3 0 1",
                     A_OUT, B_OUT, OP_OUT, STATE, LOAD_PULSE, RESULT_VALID);
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_capture_sequence();
        test_undo();
        test_undo_wins();
        test_op_check();
        test_reset_priority();
        test_in_ignored();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
